// File: rtl/vending_machine_param.sv
// Parametrised vending controller: N products with per-product prices and
// stock counters. Handles coin accept/reject, cancel with refund, sold-out
// and selection-error reporting. Change is paid serially, one 5-unit coin
// per cycle, for a downstream coin-hopper driver.
module vending_machine_param #(
   parameter int unsigned NUM_PRODUCTS = 5,
   parameter int unsigned VAL_W        = 8,
   parameter logic [NUM_PRODUCTS*VAL_W-1:0] PRICES = {8'd35, 8'd30, 8'd25, 8'd20, 8'd15},
   parameter int unsigned MAX_BALANCE  = 60,
   parameter int unsigned STOCK_W      = 4,
   parameter int unsigned INIT_STOCK   = 8,
   localparam int unsigned SEL_W       = $clog2(NUM_PRODUCTS)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    coin_valid_i,
   input  logic [3:0]              coin_i,
   input  logic                    select_valid_i,
   input  logic [SEL_W-1:0]        select_i,
   input  logic                    cancel_i,
   input  logic                    restock_i,
   output logic [NUM_PRODUCTS-1:0] deliver_o,
   output logic                    change_coin_o,
   output logic                    coin_reject_o,
   output logic                    sel_error_o,
   output logic [NUM_PRODUCTS-1:0] sold_out_o,
   output logic [VAL_W-1:0]        balance_o,
   output logic                    busy_o
);

   localparam int unsigned COIN_UNIT = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      VEND    = 2'd2,
      CHANGE  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [VAL_W-1:0]   balance_q, balance_d;
   logic [VAL_W-1:0]   remainder_q, remainder_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [STOCK_W-1:0] stock_q [NUM_PRODUCTS];
   logic [STOCK_W-1:0] stock_d [NUM_PRODUCTS];
   logic               coin_reject_q, coin_reject_d;
   logic               sel_error_q, sel_error_d;

   logic [VAL_W-1:0]   sel_price_c;
   logic [STOCK_W-1:0] sel_stock_c;
   logic               sel_in_range_c;
   logic               sel_ok_c;
   logic               coin_legal_c;
   logic               coin_fits_c;

   // Look up price and stock of the requested product (zero when out of range).
   always_comb begin
      sel_price_c = '0;
      sel_stock_c = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (select_i == SEL_W'(i)) begin
            sel_price_c = PRICES[i*VAL_W +: VAL_W];
            sel_stock_c = stock_q[i];
         end
      end
   end

   // Acceptance terms for selections and coins; the coin sum is one bit wider.
   always_comb begin
      sel_in_range_c = (32'(select_i) < NUM_PRODUCTS);
      sel_ok_c       = sel_in_range_c && (sel_stock_c != '0) && (balance_q >= sel_price_c);
      coin_legal_c   = (coin_i == 4'd5) || (coin_i == 4'd10);
      coin_fits_c    = (({1'b0, balance_q} + (VAL_W+1)'(coin_i)) <= (VAL_W+1)'(MAX_BALANCE));
   end

   // Next-state and register-update logic.
   always_comb begin
      state_d       = state_q;
      balance_d     = balance_q;
      remainder_d   = remainder_q;
      sel_d         = sel_q;
      stock_d       = stock_q;
      coin_reject_d = 1'b0;
      sel_error_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (coin_valid_i) begin
               if (coin_legal_c) begin
                  balance_d = VAL_W'(coin_i);
                  state_d   = COLLECT;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
            sel_error_d = select_valid_i;
            if (restock_i) begin
               for (int i = 0; i < NUM_PRODUCTS; i++) begin
                  stock_d[i] = STOCK_W'(INIT_STOCK);
               end
            end
         end

         COLLECT: begin
            if (cancel_i) begin
               remainder_d   = balance_q;
               balance_d     = '0;
               state_d       = CHANGE;
               coin_reject_d = coin_valid_i;
            end else if (select_valid_i) begin
               if (sel_ok_c) begin
                  sel_d       = select_i;
                  remainder_d = balance_q - sel_price_c;
                  balance_d   = '0;
                  state_d     = VEND;
               end else begin
                  sel_error_d = 1'b1;
               end
               coin_reject_d = coin_valid_i;
            end else if (coin_valid_i) begin
               if (coin_legal_c && coin_fits_c) begin
                  balance_d = balance_q + VAL_W'(coin_i);
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end

         VEND: begin
            for (int i = 0; i < NUM_PRODUCTS; i++) begin
               if ((sel_q == SEL_W'(i)) && (stock_q[i] != '0)) begin
                  stock_d[i] = stock_q[i] - STOCK_W'(1);
               end
            end
            state_d       = (remainder_q == '0) ? IDLE : CHANGE;
            coin_reject_d = coin_valid_i;
            sel_error_d   = select_valid_i;
         end

         CHANGE: begin
            remainder_d = remainder_q - VAL_W'(COIN_UNIT);
            if (remainder_q <= VAL_W'(COIN_UNIT)) begin
               remainder_d = '0;
               state_d     = IDLE;
            end
            coin_reject_d = coin_valid_i;
            sel_error_d   = select_valid_i;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         balance_q     <= '0;
         remainder_q   <= '0;
         sel_q         <= '0;
         coin_reject_q <= 1'b0;
         sel_error_q   <= 1'b0;
         for (int i = 0; i < NUM_PRODUCTS; i++) begin
            stock_q[i] <= STOCK_W'(INIT_STOCK);
         end
      end else begin
         state_q       <= state_d;
         balance_q     <= balance_d;
         remainder_q   <= remainder_d;
         sel_q         <= sel_d;
         coin_reject_q <= coin_reject_d;
         sel_error_q   <= sel_error_d;
         for (int i = 0; i < NUM_PRODUCTS; i++) begin
            stock_q[i] <= stock_d[i];
         end
      end
   end

   // Output decode from registered state and stock counters.
   always_comb begin
      deliver_o = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         deliver_o[i]  = (state_q == VEND) && (sel_q == SEL_W'(i));
         sold_out_o[i] = (stock_q[i] == '0);
      end
      change_coin_o = (state_q == CHANGE);
      busy_o        = (state_q == VEND) || (state_q == CHANGE);
      coin_reject_o = coin_reject_q;
      sel_error_o   = sel_error_q;
      balance_o     = balance_q;
   end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed self-checking bench for vending_machine_param (default parameters:
// prices 15/20/25/30/35, max balance 60, initial stock 8).
module tb_vending_machine_param;

   logic       clk = 1'b0;
   logic       rst;
   logic       coin_valid;
   logic [3:0] coin;
   logic       select_valid;
   logic [2:0] select;
   logic       cancel;
   logic       restock;
   logic [4:0] deliver;
   logic       change_coin;
   logic       coin_reject;
   logic       sel_error;
   logic [4:0] sold_out;
   logic [7:0] balance;
   logic       busy;

   int checks   = 0;
   int failures = 0;
   int busy_cyc;
   int coins_out;

   vending_machine_param dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .coin_valid_i   (coin_valid),
      .coin_i         (coin),
      .select_valid_i (select_valid),
      .select_i       (select),
      .cancel_i       (cancel),
      .restock_i      (restock),
      .deliver_o      (deliver),
      .change_coin_o  (change_coin),
      .coin_reject_o  (coin_reject),
      .sel_error_o    (sel_error),
      .sold_out_o     (sold_out),
      .balance_o      (balance),
      .busy_o         (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // One clock edge; outputs are sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_coin(input int v);
      coin_valid = 1'b1;
      coin       = 4'(v);
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic put_sel(input int s);
      select_valid = 1'b1;
      select       = 3'(s);
      tick();
      select_valid = 1'b0;
   endtask

   task automatic put_cancel();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
   endtask

   // Counts busy cycles and change pulses until the machine is idle again.
   task automatic run_until_idle(output int nbusy, output int ncoins);
      int n;
      nbusy  = 0;
      ncoins = 0;
      n      = 0;
      while (busy && n < 100) begin
         nbusy++;
         if (change_coin) ncoins++;
         tick();
         n++;
      end
      check("idle_reached", int'(busy), 0);
   endtask

   initial begin
      rst = 1'b1; coin_valid = 1'b0; coin = '0; select_valid = 1'b0;
      select = '0; cancel = 1'b0; restock = 1'b0;
      #2;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_balance", int'(balance), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_deliver", int'(deliver), 0);
      check("rst_change", int'(change_coin), 0);
      check("rst_sold_out", int'(sold_out), 0);

      // Cancel in IDLE is ignored
      put_cancel();
      check("idle_cancel_busy", int'(busy), 0);

      // Exact payment for product 0 (15)
      put_coin(10);
      check("bal_10", int'(balance), 10);
      put_coin(5);
      check("bal_15", int'(balance), 15);
      put_sel(0);
      check("p0_deliver", int'(deliver), 1);
      check("p0_busy", int'(busy), 1);
      check("p0_bal_vend", int'(balance), 0);
      tick();
      check("p0_deliver_off", int'(deliver), 0);
      check("p0_no_change", int'(change_coin), 0);
      check("p0_idle", int'(busy), 0);

      // 30 for product 1 (20): two change coins, busy three cycles
      put_coin(10); put_coin(10); put_coin(10);
      check("bal_30", int'(balance), 30);
      put_sel(1);
      check("p1_deliver", int'(deliver), 2);
      run_until_idle(busy_cyc, coins_out);
      check("p1_busy_cycles", busy_cyc, 3);
      check("p1_change", coins_out, 2);

      // Insufficient balance and out-of-range index are refused
      put_coin(10); put_coin(5);
      put_sel(3);
      check("p3_short_err", int'(sel_error), 1);
      check("p3_short_bal", int'(balance), 15);
      check("p3_short_busy", int'(busy), 0);
      put_sel(6);
      check("sel_range_err", int'(sel_error), 1);
      tick();
      check("sel_err_pulse", int'(sel_error), 0);
      put_coin(10); put_coin(5);
      check("bal_30b", int'(balance), 30);
      put_sel(3);
      check("p3_deliver", int'(deliver), 8);
      run_until_idle(busy_cyc, coins_out);
      check("p3_busy_cycles", busy_cyc, 1);
      check("p3_change", coins_out, 0);

      // Illegal coin in IDLE, balance ceiling, full refund
      put_coin(7);
      check("idle_coin7_rej", int'(coin_reject), 1);
      check("idle_coin7_bal", int'(balance), 0);
      for (int i = 0; i < 6; i++) put_coin(10);
      check("bal_60", int'(balance), 60);
      check("bal_60_no_rej", int'(coin_reject), 0);
      put_coin(10);
      check("max_rej", int'(coin_reject), 1);
      check("max_bal", int'(balance), 60);
      put_coin(5);
      check("max_rej5", int'(coin_reject), 1);
      put_cancel();
      check("cancel_bal", int'(balance), 0);
      run_until_idle(busy_cyc, coins_out);
      check("cancel_change", coins_out, 12);
      check("cancel_busy", busy_cyc, 12);

      // Sell out product 4 (35)
      for (int k = 0; k < 8; k++) begin
         put_coin(10); put_coin(10); put_coin(10); put_coin(5);
         put_sel(4);
         check("p4_deliver", int'(deliver), 16);
         run_until_idle(busy_cyc, coins_out);
         if (k == 6) check("p4_not_sold_out", int'(sold_out), 0);
      end
      check("p4_sold_out", int'(sold_out), 16);
      put_coin(10); put_coin(10); put_coin(10); put_coin(5);
      put_sel(4);
      check("p4_so_err", int'(sel_error), 1);
      check("p4_so_bal", int'(balance), 35);
      restock = 1'b1;
      tick();
      restock = 1'b0;
      check("restock_collect_ignored", int'(sold_out), 16);
      put_cancel();
      run_until_idle(busy_cyc, coins_out);
      check("p4_refund", coins_out, 7);
      restock = 1'b1;
      tick();
      restock = 1'b0;
      check("restock_idle", int'(sold_out), 0);

      // Reset during CHANGE with 15 remaining
      put_coin(10); put_coin(10); put_coin(10);
      put_sel(0);
      check("rc_deliver", int'(deliver), 1);
      tick();
      check("rc_change_on", int'(change_coin), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rc_change_off", int'(change_coin), 0);
      check("rc_busy", int'(busy), 0);
      check("rc_balance", int'(balance), 0);
      check("rc_sold_out", int'(sold_out), 0);
      tick();
      check("rc_stays_idle", int'(change_coin), 0);

      // Coin together with a selection in COLLECT: select wins, coin rejected
      put_coin(10); put_coin(10);
      coin_valid = 1'b1; coin = 4'd5; select_valid = 1'b1; select = 3'd1;
      tick();
      coin_valid = 1'b0; select_valid = 1'b0;
      check("same_deliver", int'(deliver), 2);
      check("same_reject", int'(coin_reject), 1);
      check("same_bal", int'(balance), 0);
      run_until_idle(busy_cyc, coins_out);
      check("same_change", coins_out, 0);

      // Coin during VEND is rejected
      put_coin(10); put_coin(10);
      put_sel(1);
      put_coin(5);
      check("vend_coin_rej", int'(coin_reject), 1);
      check("vend_bal", int'(balance), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vending_machine_param.md
Name: vending_machine_param

Overview:
Parametrised successor of the 4-product vending controller. Supports N products with per-product prices and a stock counter per product. Adds coin reject, cancel/refund, and sold-out/selection-error reporting. Change is paid serially as one 5-unit coin per cycle, for a downstream coin-hopper driver.

Parameters:
NUM_PRODUCTS, 5, number of products (2..16); SEL_W = clog2(NUM_PRODUCTS), derived localparam
VAL_W, 8, width of balance/price/change arithmetic
PRICES, {8'd35,8'd30,8'd25,8'd20,8'd15}, packed NUM_PRODUCTS*VAL_W prices, product i at bits [i*VAL_W +: VAL_W]; each a nonzero multiple of 5
MAX_BALANCE, 60, highest balance the machine will hold; multiple of 5, <= 2^VAL_W-1
STOCK_W, 4, width of each stock counter
INIT_STOCK, 8, stock value loaded at reset and on restock

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
coin_valid  in  1  one-cycle strobe: coin present on coin
coin  in  4  coin value; only 5 and 10 are legal
select_valid  in  1  one-cycle strobe: product request on select
select  in  SEL_W  product index
cancel  in  1  one-cycle strobe: abort and refund balance
restock  in  1  reload all stock counters to INIT_STOCK
deliver  out  NUM_PRODUCTS  one-hot, one-cycle dispense pulse
change_coin  out  1  one-cycle pulse per 5-unit coin returned
coin_reject  out  1  one-cycle pulse: last coin returned unaccepted
sel_error  out  1  one-cycle pulse: request refused
sold_out  out  NUM_PRODUCTS  bit i high when stock[i]==0
balance  out  VAL_W  current credited balance
busy  out  1  high in VEND and CHANGE

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE, balance=0, change remainder=0.
  - Every stock counter = INIT_STOCK.
  - deliver, change_coin, coin_reject, sel_error all 0.
  - rst dominates every other input, including mid-VEND and mid-CHANGE; no pending change is paid.
- coin_reject and sel_error are registered: they pulse in the cycle after the offending strobe.
- deliver and change_coin are decoded from registered state.
- State machine:
  - IDLE:
    - A legal coin (5/10) sets balance=coin and moves to COLLECT.
    - An illegal coin value pulses coin_reject.
    - select_valid pulses sel_error.
    - cancel is ignored.
    - restock is honoured only in IDLE; ignored in every other state.
  - COLLECT, one action per cycle, priority cancel > select_valid > coin_valid:
    - cancel: remainder=balance, balance=0, go to CHANGE.
    - select_valid: accepted if select<NUM_PRODUCTS, stock[select]!=0 and balance>=price[select].
      - Accepted: latch index, go to VEND.
      - Refused: pulse sel_error and stay in COLLECT with balance unchanged.
    - coin_valid with a legal value and balance+coin<=MAX_BALANCE: balance+=coin.
    - Otherwise, or any coin arriving in the same cycle as cancel/select_valid: pulse coin_reject.
  - VEND (exactly 1 cycle):
    - deliver[latched]=1; stock[latched] decrements.
    - remainder=balance-price; balance=0.
    - Next state: IDLE if remainder==0, else CHANGE.
  - CHANGE:
    - change_coin=1 every cycle; remainder-=5.
    - Leave for IDLE in the cycle after the last coin (remainder reaches 0).
    - Pulses = refund/5, back to back.
- In VEND/CHANGE: every coin_valid pulses coin_reject; select_valid pulses sel_error; cancel is ignored.
- Arithmetic:
  - All compares are unsigned at VAL_W.
  - Balance can never exceed MAX_BALANCE, so no overflow is possible.
  - Remainder is always a multiple of 5.
- Stock counters saturate at 0; they cannot underflow because a vend requires stock!=0.
- sold_out is combinational from the stock counters.
- balance output shows the live register; it is 0 in VEND and CHANGE.

Test Plan:
- Reset, then coin 10, 5, select=0 (price 15) → deliver[0] pulses one cycle, no change_coin, returns to IDLE, stock[0]=7.
- Coins 10,10,10, select=1 (price 20) → deliver[1], then exactly 2 consecutive change_coin pulses, busy high 3 cycles.
- Coins 10, 5, select=3 (price 30) → sel_error, balance stays 15; then coins 10, 5, select=3 → deliver[3], no change.
- Coins totalling 60, then coin 10 → coin_reject, balance 60; coin 7 in IDLE → coin_reject; cancel at balance 60 → 12 change_coin pulses.
- Vend product 4 eight times → sold_out[4]=1; a further request for product 4 → sel_error; restock in IDLE → sold_out[4]=0.
- Assert rst during CHANGE with remainder 15 → next cycle IDLE, change_coin=0, balance=0, all stock=INIT_STOCK; same-cycle coin+select in COLLECT → select served, coin_reject pulses.
